lwlr_ctrl: RTL and testbench

LWLR_CTRL -- requirements
Module: lwlr_ctrl

---
 rtl/lwlr_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lwlr_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lwlr_ctrl.sv
// Load controller for LW/LWL/LWR: one outstanding data-SRAM read, byte merge into rt.
// Optional LWLR_ADEL_CHECK_EN: misaligned LW raises wb_adel instead of issuing a read.
module lwlr_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_rt_old,
    input  logic [4:0]        in_rt_idx,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_data,
    output logic [3:0]        wb_we,
`ifdef LWLR_ADEL_CHECK_EN
    output logic              wb_adel,
`endif
    output logic [4:0]        wb_rt_idx
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StResp, StDrain} state_t;

    localparam logic [1:0] OpLwl = 2'b01;
    localparam logic [1:0] OpLwr = 2'b10;

    state_t      state;
    logic [1:0]  op_q;
    logic [1:0]  k_q;
    logic [31:0] rt_old_q;
    logic [4:0]  rt_idx_q;

    // Returns {we, data}; reserved op 11 falls through to plain LW.
    function automatic logic [35:0] merge_load(input logic [1:0] op, input logic [1:0] k,
                                               input logic [31:0] rt_old,
                                               input logic [31:0] mem);
        logic [31:0] d;
        logic [3:0]  we;
        int          kk;
        kk = {30'd0, k};
        d  = rt_old;
        we = 4'b0000;
        case (op)
            OpLwl: begin
                for (int j = 0; j < 4; j++) begin
                    if (j >= 3 - kk) begin
                        d[8*j +: 8] = mem[8*(j-(3-kk)) +: 8];
                        we[j]       = 1'b1;
                    end
                end
            end
            OpLwr: begin
                for (int j = 0; j < 4; j++) begin
                    if (j <= 3 - kk) begin
                        d[8*j +: 8] = mem[8*(j+kk) +: 8];
                        we[j]       = 1'b1;
                    end
                end
            end
            default: begin
                d  = mem;
                we = 4'b1111;
            end
        endcase
        return {we, d};
    endfunction

`ifdef LWLR_ADEL_CHECK_EN
    logic adel_hit;
    assign adel_hit = (in_op == 2'b00 || in_op == 2'b11) && (in_addr[1:0] != 2'b00);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            in_ready  <= 1'b1;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            wb_valid  <= 1'b0;
            wb_data   <= '0;
            wb_we     <= '0;
            wb_rt_idx <= '0;
`ifdef LWLR_ADEL_CHECK_EN
            wb_adel   <= 1'b0;
`endif
            op_q      <= '0;
            k_q       <= '0;
            rt_old_q  <= '0;
            rt_idx_q  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    // flush wins over a simultaneous request
                    if (in_valid && in_ready && !flush) begin
                        op_q     <= in_op;
                        k_q      <= in_addr[1:0];
                        rt_old_q <= in_rt_old;
                        rt_idx_q <= in_rt_idx;
                        in_ready <= 1'b0;
`ifdef LWLR_ADEL_CHECK_EN
                        if (adel_hit) begin
                            state     <= StResp;
                            wb_valid  <= 1'b1;
                            wb_adel   <= 1'b1;
                            wb_rt_idx <= in_rt_idx;
                        end else begin
                            state    <= StReq;
                            mem_req  <= 1'b1;
                            mem_addr <= {in_addr[ADDR_W-1:2], 2'b00};
                        end
`else
                        state    <= StReq;
                        mem_req  <= 1'b1;
                        mem_addr <= {in_addr[ADDR_W-1:2], 2'b00};
`endif
                    end
                end
                StReq: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        state   <= flush ? StDrain : StWait;
                    end else if (flush) begin
                        mem_req  <= 1'b0;
                        state    <= StIdle;
                        in_ready <= 1'b1;
                    end
                end
                StWait: begin
                    if (mem_data_ok) begin
                        // a flush arriving with the data simply discards it
                        if (flush) begin
                            state    <= StIdle;
                            in_ready <= 1'b1;
                        end else begin
                            state                <= StResp;
                            wb_valid             <= 1'b1;
                            {wb_we, wb_data}     <= merge_load(op_q, k_q, rt_old_q, mem_rdata);
                            wb_rt_idx            <= rt_idx_q;
                        end
                    end else if (flush) begin
                        state <= StDrain;
                    end
                end
                StResp: begin
                    if (flush || wb_ready) begin
                        state     <= StIdle;
                        in_ready  <= 1'b1;
                        wb_valid  <= 1'b0;
                        wb_data   <= '0;
                        wb_we     <= '0;
                        wb_rt_idx <= '0;
`ifdef LWLR_ADEL_CHECK_EN
                        wb_adel   <= 1'b0;
`endif
                    end
                end
                StDrain: begin
                    if (mem_data_ok) begin
                        state    <= StIdle;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= StIdle;
                    in_ready <= 1'b1;
                    mem_req  <= 1'b0;
                    wb_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lwlr_ctrl.sv
// Directed self-checking bench for lwlr_ctrl; define LWLR_ADEL_CHECK_EN to cover wb_adel.
`timescale 1ns/1ps
module tb_lwlr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_rt_old;
    logic [4:0]  in_rt_idx;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [3:0]  wb_we;
    logic [4:0]  wb_rt_idx;
`ifdef LWLR_ADEL_CHECK_EN
    logic        wb_adel;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lwlr_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_addr    (in_addr),
        .in_rt_old  (in_rt_old),
        .in_rt_idx  (in_rt_idx),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_we      (wb_we),
`ifdef LWLR_ADEL_CHECK_EN
        .wb_adel    (wb_adel),
`endif
        .wb_rt_idx  (wb_rt_idx)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Minimum-latency transaction; reports what the DUT showed, comparisons stay in callers.
    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] rt_old,
                         input logic [31:0] rdata, output int lat, output logic [31:0] maddr,
                         output logic [31:0] data, output logic [3:0] we,
                         output logic [4:0] idx);
        in_valid  = 1'b1;
        in_op     = op;
        in_addr   = addr;
        in_rt_old = rt_old;
        in_rt_idx = 5'd7;
        tick();
        in_valid    = 1'b0;
        lat         = 1;
        maddr       = mem_addr;
        mem_addr_ok = 1'b1;
        tick();
        lat         = 2;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = rdata;
        tick();
        lat         = 3;
        mem_data_ok = 1'b0;
        while (!wb_valid && lat < 20) begin
            tick();
            lat++;
        end
        data     = wb_data;
        we       = wb_we;
        idx      = wb_rt_idx;
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, mem_req, wb_valid} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 100", {in_ready, mem_req, wb_valid});
        end
        checks++;
        if ({wb_we, wb_data, wb_rt_idx} !== 41'd0) begin
            errors++;
            $display("FAIL reset_wb: got we=%b data=%h idx=%0d expected zeros",
                     wb_we, wb_data, wb_rt_idx);
        end
`ifdef LWLR_ADEL_CHECK_EN
        checks++;
        if (wb_adel !== 1'b0) begin
            errors++;
            $display("FAIL reset_adel: got %b expected 0", wb_adel);
        end
`endif
    endtask

    task automatic test_lw();
        int lat; logic [31:0] ma, d; logic [3:0] we; logic [4:0] idx;
        issue(2'b00, 32'h100, 32'hAABBCCDD, 32'h44332211, lat, ma, d, we, idx);
        checks++;
        if (ma !== 32'h100) begin
            errors++; $display("FAIL lw_addr: got %h expected 00000100", ma);
        end
        checks++;
        if (d !== 32'h44332211 || we !== 4'b1111) begin
            errors++; $display("FAIL lw_data: got %h/%b expected 44332211/1111", d, we);
        end
        checks++;
        if (lat !== 3) begin
            errors++; $display("FAIL lw_latency: got %0d expected 3", lat);
        end
        checks++;
        if (idx !== 5'd7) begin
            errors++; $display("FAIL lw_rt_idx: got %0d expected 7", idx);
        end
        checks++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0 || wb_data !== 32'h0 || wb_we !== 4'h0) begin
            errors++;
            $display("FAIL lw_after: got rdy=%b v=%b d=%h we=%b expected 1 0 0 0",
                     in_ready, wb_valid, wb_data, wb_we);
        end
    endtask

    task automatic test_lwl_lwr();
        int lat; logic [31:0] ma, d; logic [3:0] we; logic [4:0] idx;
        issue(2'b01, 32'h101, 32'hAABBCCDD, 32'h44332211, lat, ma, d, we, idx);
        checks++;
        if (d !== 32'h2211CCDD || we !== 4'b1100) begin
            errors++; $display("FAIL lwl_101: got %h/%b expected 2211ccdd/1100", d, we);
        end
        issue(2'b10, 32'h102, 32'hAABBCCDD, 32'h44332211, lat, ma, d, we, idx);
        checks++;
        if (ma !== 32'h100 || d !== 32'hAABB4433 || we !== 4'b0011) begin
            errors++;
            $display("FAIL lwr_102: got %h %h/%b expected 00000100 aabb4433/0011", ma, d, we);
        end
        issue(2'b01, 32'h103, 32'hAABBCCDD, 32'h44332211, lat, ma, d, we, idx);
        checks++;
        if (d !== 32'h44332211 || we !== 4'b1111) begin
            errors++; $display("FAIL lwl_103: got %h/%b expected 44332211/1111", d, we);
        end
        issue(2'b10, 32'h100, 32'hAABBCCDD, 32'h44332211, lat, ma, d, we, idx);
        checks++;
        if (d !== 32'h44332211 || we !== 4'b1111) begin
            errors++; $display("FAIL lwr_100: got %h/%b expected 44332211/1111", d, we);
        end
        issue(2'b01, 32'h100, 32'hAABBCCDD, 32'h44332211, lat, ma, d, we, idx);
        checks++;
        if (d !== 32'h11BBCCDD || we !== 4'b1000) begin
            errors++; $display("FAIL lwl_100: got %h/%b expected 11bbccdd/1000", d, we);
        end
        issue(2'b10, 32'h103, 32'hAABBCCDD, 32'h44332211, lat, ma, d, we, idx);
        checks++;
        if (d !== 32'hAABBCC44 || we !== 4'b0001) begin
            errors++; $display("FAIL lwr_103: got %h/%b expected aabbcc44/0001", d, we);
        end
        issue(2'b11, 32'h104, 32'hAABBCCDD, 32'h55667788, lat, ma, d, we, idx);
        checks++;
        if (ma !== 32'h104 || d !== 32'h55667788 || we !== 4'b1111) begin
            errors++; $display("FAIL op11_as_lw: got %h %h/%b expected 00000104 55667788/1111",
                               ma, d, we);
        end
    endtask

    task automatic test_stall();
        in_valid = 1'b1; in_op = 2'b00; in_addr = 32'h200;
        in_rt_old = 32'h0; in_rt_idx = 5'd9;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
                errors++; $display("FAIL stall_req%0d: got %b %h expected 1 00000200",
                                   i, mem_req, mem_addr);
            end
            tick();
        end
        // data_ok alongside addr_ok must be ignored
        mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_req !== 1'b0 || wb_valid !== 1'b0) begin
                errors++; $display("FAIL stall_wait%0d: got req=%b v=%b expected 0 0",
                                   i, mem_req, wb_valid);
            end
            tick();
        end
        mem_data_ok = 1'b1; mem_rdata = 32'h55667788;
        tick();
        mem_data_ok = 1'b0; mem_rdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wb_valid !== 1'b1 || wb_data !== 32'h55667788 || wb_we !== 4'b1111 ||
                wb_rt_idx !== 5'd9) begin
                errors++; $display("FAIL stall_resp%0d: got v=%b %h/%b idx=%0d expected 1 55667788/1111 9",
                                   i, wb_valid, wb_data, wb_we, wb_rt_idx);
            end
            tick();
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_done: got v=%b rdy=%b expected 0 1", wb_valid, in_ready);
        end
    endtask

    task automatic test_flush_wait();
        int lat; logic [31:0] ma, d; logic [3:0] we; logic [4:0] idx;
        in_valid = 1'b1; in_op = 2'b00; in_addr = 32'h300;
        tick();
        in_valid = 1'b0; mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL fw_drain1: got rdy=%b v=%b expected 0 0", in_ready, wb_valid);
        end
        tick();
        mem_data_ok = 1'b1; mem_rdata = 32'hBADBAD00;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL fw_drain2: got rdy=%b expected 0", in_ready);
        end
        tick();
        mem_data_ok = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL fw_idle: got rdy=%b v=%b expected 1 0", in_ready, wb_valid);
        end
        issue(2'b00, 32'h100, 32'hAABBCCDD, 32'h44332211, lat, ma, d, we, idx);
        checks++;
        if (d !== 32'h44332211 || we !== 4'b1111 || lat !== 3) begin
            errors++; $display("FAIL fw_next: got %h/%b lat=%0d expected 44332211/1111 3", d, we, lat);
        end
    endtask

    task automatic test_flush_other();
        // flush beats in_valid in IDLE
        in_valid = 1'b1; in_op = 2'b00; in_addr = 32'h400; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL flush_idle: got rdy=%b req=%b expected 1 0", in_ready, mem_req);
        end
        // flush in REQ before addr_ok
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL flush_req: got rdy=%b req=%b expected 1 0", in_ready, mem_req);
        end
        // flush in REQ together with addr_ok goes to drain
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b1; mem_addr_ok = 1'b1;
        tick();
        flush = 1'b0; mem_addr_ok = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL flush_req_ok: got rdy=%b req=%b expected 0 0", in_ready, mem_req);
        end
        mem_data_ok = 1'b1;
        tick();
        mem_data_ok = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL flush_req_drain: got rdy=%b v=%b expected 1 0", in_ready, wb_valid);
        end
        // flush in RESP drops the result
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_data_ok = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || wb_data !== 32'h0 || wb_we !== 4'h0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_resp: got v=%b %h/%b rdy=%b expected 0 0/0 1",
                               wb_valid, wb_data, wb_we, in_ready);
        end
    endtask

    task automatic test_misaligned_lw();
`ifdef LWLR_ADEL_CHECK_EN
        in_valid = 1'b1; in_op = 2'b00; in_addr = 32'h103; in_rt_idx = 5'd3;
        tick();
        in_valid = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_adel !== 1'b1 || wb_we !== 4'b0000) begin
            errors++; $display("FAIL adel: got req=%b v=%b adel=%b we=%b expected 0 1 1 0000",
                               mem_req, wb_valid, wb_adel, wb_we);
        end
        wb_ready = 1'b1;
        tick();
        wb_ready = 1'b0;
        checks++;
        if (wb_adel !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL adel_clear: got adel=%b v=%b rdy=%b expected 0 0 1",
                               wb_adel, wb_valid, in_ready);
        end
`else
        int lat; logic [31:0] ma, d; logic [3:0] we; logic [4:0] idx;
        issue(2'b00, 32'h103, 32'hAABBCCDD, 32'h44332211, lat, ma, d, we, idx);
        checks++;
        if (ma !== 32'h100 || d !== 32'h44332211 || we !== 4'b1111) begin
            errors++; $display("FAIL lw_unaligned: got %h %h/%b expected 00000100 44332211/1111",
                               ma, d, we);
        end
`endif
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_op = 2'b00; in_addr = 32'h500;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid: got req=%b rdy=%b expected 0 1", mem_req, in_ready);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_addr = '0; in_rt_old = '0;
        in_rt_idx = '0; flush = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
        mem_rdata = '0; wb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        tick();
        test_lw();
        test_lwl_lwr();
        test_stall();
        test_flush_wait();
        test_flush_other();
        test_misaligned_lw();
        test_reset_mid();
        test_lw();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
